// File: rtl/up_pkg.sv
// Shared types for the program/data RAM arbiter.
//   DW, AW      RAM word and address widths
//   src_t       requester identity (m0 = uP core, m1 = loader/DMA)
//   mem_cmd_t   one accepted command as held in the access stage
package up_pkg;

   localparam int DW = 8;
   localparam int AW = 8;

   typedef enum logic {
      SRC_M0 = 1'b0,
      SRC_M1 = 1'b1
   } src_t;

   typedef struct packed {
      src_t            src;
      logic            we;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   wdata;
   } mem_cmd_t;

   function automatic src_t other_src(input src_t s);
      return (s == SRC_M0) ? SRC_M1 : SRC_M0;
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection for the two RAM requesters.
//   req[1:0]      request levels, bit 0 = m0, bit 1 = m1
//   rr_ptr        side that wins an unlocked tie
//   owner         last winner
//   owner_locked  last winner asked to keep the RAM and has not gone idle
//   burst_cnt     consecutive grants held by owner (saturating)
//   winner/valid  selected requester, valid when anyone requests
module arb_pick
   import up_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int BW        = 3
)
(
   input  logic [1:0]    req,
   input  src_t          rr_ptr,
   input  src_t          owner,
   input  logic          owner_locked,
   input  logic [BW-1:0] burst_cnt,
   output src_t          winner,
   output logic          valid
);

   localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BURST);

   always_comb begin
      valid  = |req;
      winner = rr_ptr;
      if (req == 2'b01) begin
         winner = SRC_M0;
      end else if (req == 2'b10) begin
         winner = SRC_M1;
      end else if (owner_locked && (burst_cnt < MAX_CNT)) begin
         // a locked owner keeps the RAM until its burst budget runs out
         winner = owner;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port program/data RAM between the uP core (m0) and the
// loader/DMA port (m1). One command accepted per cycle, one access per cycle.
//   clock, reset              system clock, synchronous active-high reset
//   mX_req/we/addr/wdata/lock command from requester X (level, held until gnt)
//   mX_gnt                    command accepted at the coming posedge
//   mX_rvalid/rdata           read data, pulse two cycles after the grant
//   mem_we/mem_addr/mem_data  RAM port; mem_data driven only while writing
module mem_arbiter
   import up_pkg::*;
#(
   parameter int MAX_BURST = 4
)
(
   input  logic          clock,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_lock,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_lock,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   inout  wire  [DW-1:0] mem_data
);

   localparam int            BW      = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BURST);

   mem_cmd_t      cmd_q,          cmd_d;
   logic          cmd_vld_q,      cmd_vld_d;
   src_t          rr_ptr_q,       rr_ptr_d;
   src_t          owner_q,        owner_d;
   logic          owner_locked_q, owner_locked_d;
   logic [BW-1:0] burst_cnt_q,    burst_cnt_d;
   logic          m0_rvalid_q,    m0_rvalid_d;
   logic          m1_rvalid_q,    m1_rvalid_d;
   logic [DW-1:0] m0_rdata_q,     m0_rdata_d;
   logic [DW-1:0] m1_rdata_q,     m1_rdata_d;

   src_t          winner;
   logic          pick_vld;
   logic          grant;
   logic          drive_bus;

   arb_pick #(
      .MAX_BURST (MAX_BURST),
      .BW        (BW)
   ) u_pick (
      .req          ({m1_req, m0_req}),
      .rr_ptr       (rr_ptr_q),
      .owner        (owner_q),
      .owner_locked (owner_locked_q),
      .burst_cnt    (burst_cnt_q),
      .winner       (winner),
      .valid        (pick_vld)
   );

   // the access stage always empties in one cycle, so nothing but reset
   // can hold off a grant
   assign grant  = pick_vld && !reset;
   assign m0_gnt = grant && (winner == SRC_M0);
   assign m1_gnt = grant && (winner == SRC_M1);

   always_comb begin
      cmd_d          = cmd_q;
      cmd_vld_d      = grant;
      rr_ptr_d       = rr_ptr_q;
      owner_d        = owner_q;
      owner_locked_d = owner_locked_q;
      burst_cnt_d    = burst_cnt_q;
      m0_rvalid_d    = 1'b0;
      m1_rvalid_d    = 1'b0;
      m0_rdata_d     = m0_rdata_q;
      m1_rdata_d     = m1_rdata_q;

      // RAM read is combinational: sample the bus at the end of the access cycle
      if (cmd_vld_q && !cmd_q.we) begin
         if (cmd_q.src == SRC_M0) begin
            m0_rvalid_d = 1'b1;
            m0_rdata_d  = mem_data;
         end else begin
            m1_rvalid_d = 1'b1;
            m1_rdata_d  = mem_data;
         end
      end

      if (grant) begin
         if (winner == SRC_M0) begin
            cmd_d          = '{src: SRC_M0, we: m0_we, addr: m0_addr, wdata: m0_wdata};
            owner_locked_d = m0_lock;
         end else begin
            cmd_d          = '{src: SRC_M1, we: m1_we, addr: m1_addr, wdata: m1_wdata};
            owner_locked_d = m1_lock;
         end
         rr_ptr_d = other_src(winner);
         owner_d  = winner;
         if (winner != owner_q) begin
            burst_cnt_d = BW'(1);
         end else if (burst_cnt_q != MAX_CNT) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
         end
      end else begin
         // an idle cycle means the owner dropped req, so its lock lapses
         owner_locked_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cmd_q          <= '0;
         cmd_vld_q      <= 1'b0;
         rr_ptr_q       <= SRC_M0;
         owner_q        <= SRC_M0;
         owner_locked_q <= 1'b0;
         burst_cnt_q    <= '0;
         m0_rvalid_q    <= 1'b0;
         m1_rvalid_q    <= 1'b0;
         m0_rdata_q     <= '0;
         m1_rdata_q     <= '0;
      end else begin
         cmd_q          <= cmd_d;
         cmd_vld_q      <= cmd_vld_d;
         rr_ptr_q       <= rr_ptr_d;
         owner_q        <= owner_d;
         owner_locked_q <= owner_locked_d;
         burst_cnt_q    <= burst_cnt_d;
         m0_rvalid_q    <= m0_rvalid_d;
         m1_rvalid_q    <= m1_rvalid_d;
         m0_rdata_q     <= m0_rdata_d;
         m1_rdata_q     <= m1_rdata_d;
      end
   end

   assign drive_bus = cmd_vld_q && cmd_q.we;
   assign mem_we    = drive_bus;
   assign mem_addr  = cmd_q.addr;
   assign mem_data  = drive_bus ? cmd_q.wdata : 'z;

   assign m0_rvalid = m0_rvalid_q;
   assign m1_rvalid = m1_rvalid_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// cycle-timeline reference model with its own RAM image.
module tb_mem_arbiter;
   import up_pkg::*;

   localparam int MAXB  = 4;
   localparam int NRAND = 300;

   logic       clock = 1'b0;
   logic       reset;
   logic       m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [7:0] m0_rdata, m1_rdata;
   logic       mem_we;
   logic [7:0] mem_addr;
   wire  [7:0] mem_data;

   logic [7:0] ram [256];
   logic       ram_init;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   // RAM: writes on posedge, combinational read drives the bus when not writing
   assign mem_data = mem_we ? 'z : ram[mem_addr];
   always @(posedge clock) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h3A;
      end else if (mem_we) begin
         ram[mem_addr] <= mem_data;
      end
   end

   mem_arbiter #(.MAX_BURST(MAXB)) dut (
      .clock     (clock),
      .reset     (reset),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_lock   (m0_lock),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_lock   (m1_lock),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data)
   );

   function automatic logic [7:0] init_val(input int a);
      return 8'(a) ^ 8'h3A;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_lock = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
   endtask

   task automatic do_reset(input logic init_ram);
      idle_inputs();
      reset    = 1'b1;
      ram_init = init_ram;
      tick();
      tick();
      reset    = 1'b0;
      ram_init = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1; ram_init = 1'b1;
      m0_req = 1; m1_req = 1;
      tick(); tick();
      ram_init = 1'b0;
      @(negedge clock);
      n_checks++; if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_m0_gnt: got %b want 0", m0_gnt); end
      n_checks++; if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_m1_gnt: got %b want 0", m1_gnt); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
      n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
      n_checks++; if (mem_data !== 8'h3A) begin n_fail++; $display("FAIL reset_bus_released: got %h want 3a", mem_data); end
      n_checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b%b want 00", m0_rvalid, m1_rvalid); end
      n_checks++; if (m0_rdata !== 8'h00 || m1_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 00 00", m0_rdata, m1_rdata); end
      tick();
      reset = 1'b0;
      idle_inputs();
      tick();
   endtask

   task automatic test_single_read();
      do_reset(1'b0);
      m0_req = 1; m0_we = 0; m0_addr = 8'h10;
      @(negedge clock);
      n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL sr_gnt: got %b%b want 10", m0_gnt, m1_gnt); end
      tick();
      idle_inputs();
      @(negedge clock);
      n_checks++; if (mem_addr !== 8'h10 || mem_we !== 1'b0) begin n_fail++; $display("FAIL sr_access: got addr %h we %b want 10 0", mem_addr, mem_we); end
      n_checks++; if (mem_data !== 8'h2A) begin n_fail++; $display("FAIL sr_bus: got %h want 2a", mem_data); end
      n_checks++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL sr_early_rvalid: got %b want 0", m0_rvalid); end
      tick();
      @(negedge clock);
      n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 8'h2A) begin n_fail++; $display("FAIL sr_rdata: got v%b %h want v1 2a", m0_rvalid, m0_rdata); end
      n_checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 8'h00) begin n_fail++; $display("FAIL sr_m1_quiet: got v%b %h want v0 00", m1_rvalid, m1_rdata); end
      tick();
      @(negedge clock);
      n_checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 8'h2A) begin n_fail++; $display("FAIL sr_pulse: got v%b %h want v0 2a", m0_rvalid, m0_rdata); end
   endtask

   task automatic test_write_then_read();
      do_reset(1'b0);
      m1_req = 1; m1_we = 1; m1_addr = 8'h33; m1_wdata = 8'h5C;
      @(negedge clock);
      n_checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL wr_gnt: got %b%b want 01", m0_gnt, m1_gnt); end
      tick();
      m1_we = 0; m1_wdata = 8'hA7;
      @(negedge clock);
      n_checks++; if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b want 1", m1_gnt); end
      n_checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h33 || mem_data !== 8'h5C) begin n_fail++; $display("FAIL wr_access: got we %b addr %h data %h want 1 33 5c", mem_we, mem_addr, mem_data); end
      tick();
      idle_inputs();
      @(negedge clock);
      n_checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h33 || mem_data !== 8'h5C) begin n_fail++; $display("FAIL rd_access: got we %b addr %h data %h want 0 33 5c", mem_we, mem_addr, mem_data); end
      n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b want 0", m1_rvalid); end
      tick();
      @(negedge clock);
      n_checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 8'h5C) begin n_fail++; $display("FAIL wr_rd_data: got v%b %h want v1 5c", m1_rvalid, m1_rdata); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_once: got mem_we %b want 0", mem_we); end
   endtask

   task automatic test_tie_no_lock();
      logic exp0;
      do_reset(1'b0);
      m0_req = 1; m0_addr = 8'h01; m1_req = 1; m1_addr = 8'h02;
      for (int i = 0; i < 6; i++) begin
         exp0 = (i % 2) == 0;
         @(negedge clock);
         n_checks++; if (m0_gnt !== exp0 || m1_gnt !== !exp0) begin n_fail++; $display("FAIL tie_%0d: got %b%b want %b%b", i, m0_gnt, m1_gnt, exp0, !exp0); end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_locked_burst();
      logic [11:0] pat;
      int          wait_cnt;
      int          max_wait;
      pat      = 12'b1110_1111_0111;
      wait_cnt = 0;
      max_wait = 0;
      do_reset(1'b0);
      m1_req = 1; m1_lock = 1; m1_addr = 8'h20;
      @(negedge clock);
      n_checks++; if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_first: got %b want 1", m1_gnt); end
      tick();
      m0_req = 1; m0_addr = 8'h21;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         n_checks++; if (m1_gnt !== pat[i] || m0_gnt !== !pat[i]) begin n_fail++; $display("FAIL lock_%0d: got %b%b want %b%b", i, m0_gnt, m1_gnt, !pat[i], pat[i]); end
         if (m0_gnt) wait_cnt = 0; else wait_cnt++;
         if (wait_cnt > max_wait) max_wait = wait_cnt;
         tick();
      end
      n_checks++; if (max_wait > MAXB) begin n_fail++; $display("FAIL lock_starve: got wait %0d want <= %0d", max_wait, MAXB); end
      idle_inputs();
      tick();
   endtask

   task automatic test_lone_streamer();
      int n_g;
      int n_rv;
      n_g  = 0;
      n_rv = 0;
      do_reset(1'b0);
      for (int c = 0; c < 12; c++) begin
         m0_req = (c < 10); m0_we = 0; m0_addr = 8'(8'h40 + c); m0_lock = 0;
         @(negedge clock);
         n_checks++; if (m0_gnt !== (c < 10) || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL lone_gnt_%0d: got %b%b want %b0", c, m0_gnt, m1_gnt, c < 10); end
         if (m0_gnt) n_g++;
         if (c >= 2) begin
            n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== init_val(8'h40 + c - 2)) begin n_fail++; $display("FAIL lone_rd_%0d: got v%b %h want v1 %h", c, m0_rvalid, m0_rdata, init_val(8'h40 + c - 2)); end
         end
         if (m0_rvalid) n_rv++;
         tick();
      end
      idle_inputs();
      n_checks++; if (n_g != 10 || n_rv != 10) begin n_fail++; $display("FAIL lone_count: got %0d gnt %0d rv want 10 10", n_g, n_rv); end
      tick();
   endtask

   task automatic test_reset_mid_flight();
      do_reset(1'b0);
      m1_req = 1; m1_lock = 1; m1_addr = 8'h05;
      @(negedge clock);
      n_checks++; if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL rmf_m1_gnt: got %b want 1", m1_gnt); end
      tick();
      idle_inputs();
      m0_req = 1; m0_addr = 8'h10;
      @(negedge clock);
      n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rmf_m0_gnt: got %b want 1", m0_gnt); end
      tick();
      reset = 1'b1;
      m0_req = 1; m1_req = 1; m1_lock = 1; m1_addr = 8'h06;
      @(negedge clock);
      n_checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL rmf_gnt_in_reset: got %b%b want 00", m0_gnt, m1_gnt); end
      tick();
      reset = 1'b0;
      m1_lock = 0;
      @(negedge clock);
      n_checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmf_dropped: got rvalid %b%b want 00", m0_rvalid, m1_rvalid); end
      n_checks++; if (mem_we !== 1'b0 || mem_data !== 8'h3A) begin n_fail++; $display("FAIL rmf_bus: got we %b data %h want 0 3a", mem_we, mem_data); end
      n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL rmf_first_tie: got %b%b want 10", m0_gnt, m1_gnt); end
      tick();
      idle_inputs();
      @(negedge clock);
      n_checks++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmf_late_rvalid: got %b want 0", m0_rvalid); end
      tick();
      tick();
   endtask

   task automatic test_random();
      // timeline model: acc_* holds the access the RAM sees in each cycle
      logic       acc_vld [NRAND+2];
      int         acc_src [NRAND+2];
      logic       acc_we  [NRAND+2];
      logic [7:0] acc_addr[NRAND+2];
      logic [7:0] acc_wd  [NRAND+2];
      logic [7:0] m_mem   [256];
      logic [7:0] md_rd   [2];
      int         last_win, run_len, rr_side, eg;
      logic       last_lock, ev0, ev1;
      logic       rq [2];
      logic       wq [2];
      logic       lk [2];
      logic [7:0] aq [2];
      logic [7:0] dq [2];

      for (int i = 0; i < NRAND + 2; i++) begin
         acc_vld[i] = 0; acc_src[i] = 0; acc_we[i] = 0; acc_addr[i] = 0; acc_wd[i] = 0;
      end
      for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
      md_rd[0] = 0; md_rd[1] = 0;
      last_win = 0; run_len = 0; rr_side = 0; last_lock = 0;
      do_reset(1'b1);

      for (int c = 0; c < NRAND; c++) begin
         for (int s = 0; s < 2; s++) begin
            rq[s] = $urandom_range(0, 9) < 7;
            wq[s] = $urandom_range(0, 2) == 0;
            lk[s] = 1'($urandom_range(0, 1));
            aq[s] = 8'($urandom_range(0, 15));
            dq[s] = 8'($urandom);
         end
         m0_req = rq[0]; m0_we = wq[0]; m0_lock = lk[0]; m0_addr = aq[0]; m0_wdata = dq[0];
         m1_req = rq[1]; m1_we = wq[1]; m1_lock = lk[1]; m1_addr = aq[1]; m1_wdata = dq[1];

         if (rq[0] && rq[1]) eg = (last_lock && run_len < MAXB) ? last_win : rr_side;
         else if (rq[0])     eg = 0;
         else if (rq[1])     eg = 1;
         else                eg = -1;
         ev0 = (c > 0) && acc_vld[c-1] && !acc_we[c-1] && acc_src[c-1] == 0;
         ev1 = (c > 0) && acc_vld[c-1] && !acc_we[c-1] && acc_src[c-1] == 1;

         @(negedge clock);
         n_checks++; if (m0_gnt !== (eg == 0) || m1_gnt !== (eg == 1)) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b%b want winner %0d", c, m0_gnt, m1_gnt, eg); end
         n_checks++; if (mem_we !== (acc_vld[c] && acc_we[c])) begin n_fail++; $display("FAIL rnd_mem_we c%0d: got %b want %b", c, mem_we, acc_vld[c] && acc_we[c]); end
         if (acc_vld[c]) begin
            n_checks++; if (mem_addr !== acc_addr[c]) begin n_fail++; $display("FAIL rnd_mem_addr c%0d: got %h want %h", c, mem_addr, acc_addr[c]); end
            n_checks++; if (mem_data !== (acc_we[c] ? acc_wd[c] : m_mem[acc_addr[c]])) begin n_fail++; $display("FAIL rnd_mem_data c%0d: got %h want %h", c, mem_data, acc_we[c] ? acc_wd[c] : m_mem[acc_addr[c]]); end
         end
         n_checks++; if (m0_rvalid !== ev0 || m0_rdata !== md_rd[0]) begin n_fail++; $display("FAIL rnd_m0_rd c%0d: got v%b %h want v%b %h", c, m0_rvalid, m0_rdata, ev0, md_rd[0]); end
         n_checks++; if (m1_rvalid !== ev1 || m1_rdata !== md_rd[1]) begin n_fail++; $display("FAIL rnd_m1_rd c%0d: got v%b %h want v%b %h", c, m1_rvalid, m1_rdata, ev1, md_rd[1]); end

         @(posedge clock);
         if (acc_vld[c]) begin
            if (acc_we[c]) m_mem[acc_addr[c]] = acc_wd[c];
            else           md_rd[acc_src[c]] = m_mem[acc_addr[c]];
         end
         if (eg >= 0) begin
            acc_vld[c+1]  = 1;
            acc_src[c+1]  = eg;
            acc_we[c+1]   = wq[eg];
            acc_addr[c+1] = aq[eg];
            acc_wd[c+1]   = dq[eg];
            if (eg == last_win) run_len = (run_len < MAXB) ? run_len + 1 : MAXB;
            else                run_len = 1;
            last_win  = eg;
            last_lock = lk[eg];
            rr_side   = 1 - eg;
         end else begin
            last_lock = 0;
         end
         #1;
      end
      idle_inputs();
      tick();
      tick();
   endtask

   initial begin
      reset    = 1'b1;
      ram_init = 1'b0;
      idle_inputs();
      test_reset();
      test_single_read();
      test_write_then_read();
      test_tie_no_lock();
      test_locked_burst();
      test_lone_streamer();
      test_reset_mid_flight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish within time limit, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
